// File: rtl/nxn_game_core.sv
// N x N K-in-a-row game core: move validation, turn order and a fixed-length
// sequential win scan around the last accepted cell.
module nxn_game_core #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int POS_W = $clog2(N*N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             move_stb,
  input  logic [1:0]       player,
  input  logic [POS_W-1:0] pos,
  output logic             move_accept,
  output logic             move_reject,
  output logic [2:0]       reject_code,
  output logic             busy,
  output logic [1:0]       turn,
  output logic [1:0]       winner,
  output logic             game_over,
  output logic             draw,
  output logic [POS_W-1:0] move_count,
  output logic [2*N*N-1:0] board
);

  localparam int BW = 2*N*N;
  localparam int IW = $clog2(BW);
  localparam logic [POS_W-1:0] CELLS = POS_W'(N*N);
  localparam logic [3:0] HALF = 4'(K-1);
  localparam logic [3:0] LAST = 4'(2*(K-1)-1);
  localparam logic [3:0] KRUN = 4'(K);
  localparam logic signed [4:0] NS = 5'(N);

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;
  state_t state, state_next;

  logic signed [4:0] org_r, org_c, cur_r, cur_c;
  logic [3:0] step, run;
  logic [1:0] dir, mover;
  logic       alive, win_found;

  // move validation
  logic [6:0]      pidx;
  logic [IW-1:0]   pbit;
  logic            pos_ok, take;
  logic [1:0]      pcell;
  logic [2:0]      code;
  logic signed [4:0] prow, pcol;

  always_comb begin
    pidx   = 7'(pos) - 7'd1;
    pbit   = IW'({pidx, 1'b0});
    pos_ok = (pos != '0) && (pos <= CELLS);
    pcell  = pos_ok ? board[pbit +: 2] : 2'b00;
    prow   = 5'(pidx / 7'(N));
    pcol   = 5'(pidx % 7'(N));
    if (busy || game_over)  code = 3'd4;
    else if (player != turn) code = 3'd1;
    else if (!pos_ok)        code = 3'd2;
    else if (pcell != 2'b00) code = 3'd3;
    else                     code = 3'd0;
    take = move_stb && (code == 3'd0);
  end

  // one scan step: each sense restarts from the origin; a dead sense keeps
  // walking so the scan length never depends on the board contents
  logic              start_sense, live, neg, inb, hit, dir_done, scan_done;
  logic signed [4:0] fr, fc, br, bc, dr, dc, nr, nc;
  logic [6:0]        sidx;
  logic [IW-1:0]     sbit;
  logic [3:0]        run_next;

  always_comb begin
    start_sense = (step == 4'd0) || (step == HALF);
    fr   = start_sense ? org_r : cur_r;
    fc   = start_sense ? org_c : cur_c;
    live = start_sense || alive;
    neg  = (step >= HALF);
    case (dir)
      2'd0:    begin br = 5'sd0; bc = 5'sd1;  end
      2'd1:    begin br = 5'sd1; bc = 5'sd0;  end
      2'd2:    begin br = 5'sd1; bc = 5'sd1;  end
      default: begin br = 5'sd1; bc = -5'sd1; end
    endcase
    dr   = neg ? -br : br;
    dc   = neg ? -bc : bc;
    nr   = fr + dr;
    nc   = fc + dc;
    inb  = !nr[4] && (nr < NS) && !nc[4] && (nc < NS);
    sidx = inb ? (7'(nr[3:0]) * 7'(N) + 7'(nc[3:0])) : '0;
    sbit = IW'({sidx, 1'b0});
    hit  = live && inb && (board[sbit +: 2] == mover);
    run_next  = ((step == 4'd0) ? 4'd1 : run) + {3'b000, hit};
    dir_done  = (step == LAST);
    scan_done = dir_done && (dir == 2'd3);
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = SCAN;
      SCAN:    if (scan_done) state_next = RESOLVE;
      RESOLVE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (new_game) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      reject_code <= '0;
      turn        <= 2'b01;
      winner      <= '0;
      game_over   <= 1'b0;
      draw        <= 1'b0;
      move_count  <= '0;
      board       <= '0;
      org_r <= '0; org_c <= '0; cur_r <= '0; cur_c <= '0;
      step  <= '0; run   <= '0; dir   <= '0; mover <= '0;
      alive <= 1'b0; win_found <= 1'b0;
    end else if (new_game) begin
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      reject_code <= '0;
      turn        <= 2'b01;
      winner      <= '0;
      game_over   <= 1'b0;
      draw        <= 1'b0;
      move_count  <= '0;
      board       <= '0;
      org_r <= '0; org_c <= '0; cur_r <= '0; cur_c <= '0;
      step  <= '0; run   <= '0; dir   <= '0; mover <= '0;
      alive <= 1'b0; win_found <= 1'b0;
    end else begin
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      if (move_stb) begin
        if (take) begin
          move_accept       <= 1'b1;
          board[pbit +: 2]  <= player;
          move_count        <= move_count + 1'b1;
          org_r             <= prow;
          org_c             <= pcol;
          mover             <= player;
          step              <= '0;
          dir               <= '0;
          win_found         <= 1'b0;
        end else begin
          move_reject <= 1'b1;
          reject_code <= code;
        end
      end
      if (state == SCAN) begin
        cur_r <= nr;
        cur_c <= nc;
        alive <= hit;
        run   <= run_next;
        if (dir_done) begin
          step <= '0;
          dir  <= dir + 2'd1;
          if (run_next >= KRUN) win_found <= 1'b1;
        end else begin
          step <= step + 4'd1;
        end
      end
      if (state == RESOLVE) begin
        if (win_found) begin
          winner    <= mover;
          game_over <= 1'b1;
        end else if (move_count == CELLS) begin
          draw      <= 1'b1;
          game_over <= 1'b1;
        end else begin
          turn <= {turn[0], turn[1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_nxn_game_core.sv
// Bench for nxn_game_core: a 3x3/K=3 and a 5x5/K=4 instance driven from
// move tables, with a pulse scoreboard and hand-written corner sequences.
module tb_nxn_game_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pl = 2'b00;
  logic [4:0]  posv = '0;
  logic        stb3 = 1'b0, ng3 = 1'b0, stb5 = 1'b0, ng5 = 1'b0;

  logic        acc3, rej3, busy3, go3, draw3;
  logic [2:0]  rc3;
  logic [1:0]  turn3, win3;
  logic [3:0]  cnt3;
  logic [17:0] board3;

  logic        acc5, rej5, busy5, go5, draw5;
  logic [2:0]  rc5;
  logic [1:0]  turn5, win5;
  logic [4:0]  cnt5;
  logic [49:0] board5;

  always #5 clk = ~clk;

  nxn_game_core #(.N(3), .K(3)) d3 (
    .clk(clk), .reset(reset), .new_game(ng3), .move_stb(stb3), .player(pl),
    .pos(posv[3:0]), .move_accept(acc3), .move_reject(rej3), .reject_code(rc3),
    .busy(busy3), .turn(turn3), .winner(win3), .game_over(go3), .draw(draw3),
    .move_count(cnt3), .board(board3));

  nxn_game_core #(.N(5), .K(4)) d5 (
    .clk(clk), .reset(reset), .new_game(ng5), .move_stb(stb5), .player(pl),
    .pos(posv), .move_accept(acc5), .move_reject(rej5), .reject_code(rc5),
    .busy(busy5), .turn(turn5), .winner(win5), .game_over(go5), .draw(draw5),
    .move_count(cnt5), .board(board5));

  int errors = 0;
  int checks = 0;

  typedef struct {int sel; logic acc; logic [2:0] code;} exp_t;
  typedef struct {int sel; logic [1:0] pl; int p; logic acc; logic [2:0] code;} vec_t;
  exp_t sbq[$];
  vec_t tbl[$];
  exp_t mon_e;
  logic [63:0] mb[2];
  int          mc[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] f_board(input int s); return (s == 0) ? 64'(board3) : 64'(board5); endfunction
  function automatic logic [63:0] f_count(input int s); return (s == 0) ? 64'(cnt3) : 64'(cnt5); endfunction
  function automatic logic f_busy(input int s); return (s == 0) ? busy3 : busy5; endfunction
  function automatic logic f_acc(input int s);  return (s == 0) ? acc3 : acc5; endfunction
  function automatic logic f_rej(input int s);  return (s == 0) ? rej3 : rej5; endfunction
  function automatic logic f_go(input int s);   return (s == 0) ? go3 : go5; endfunction
  function automatic logic f_draw(input int s); return (s == 0) ? draw3 : draw5; endfunction
  function automatic logic [1:0] f_turn(input int s); return (s == 0) ? turn3 : turn5; endfunction
  function automatic logic [1:0] f_win(input int s);  return (s == 0) ? win3 : win5; endfunction
  function automatic logic [2:0] f_rc(input int s);   return (s == 0) ? rc3 : rc5; endfunction

  function automatic logic [63:0] mk(input int cells, input logic [63:0] m1, input logic [63:0] m2);
    logic [63:0] r = '0;
    for (int i = 0; i < cells; i++) begin
      if (m1[i]) r[2*i +: 2] = 2'b01;
      if (m2[i]) r[2*i +: 2] = 2'b10;
    end
    return r;
  endfunction

  // every accept/reject pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (f_acc(s) || f_rej(s)) begin
        if (sbq.size() == 0) begin
          check("unexpected_pulse", 64'({f_acc(s), f_rej(s)}), 64'(0));
        end else begin
          mon_e = sbq.pop_front();
          check("pulse_sel", 64'(s), 64'(mon_e.sel));
          check("pulse_kind", 64'({f_acc(s), f_rej(s)}), mon_e.acc ? 64'(2) : 64'(1));
          if (!mon_e.acc) check("reject_code", 64'(f_rc(s)), 64'(mon_e.code));
        end
      end
    end
  end

  task automatic drive(input int s, input logic [1:0] p, input int position,
                       input logic acc, input logic [2:0] code, input bit wait_busy);
    int n;
    sbq.push_back('{s, acc, code});
    pl = p;
    posv = 5'(position);
    if (s == 0) stb3 = 1'b1; else stb5 = 1'b1;
    @(negedge clk);
    stb3 = 1'b0;
    stb5 = 1'b0;
    #1;
    check("pulse_seen", 64'(sbq.size()), 64'(0));
    if (acc) begin
      mb[s][2*(position-1) +: 2] = p;
      mc[s]++;
    end
    if (acc && wait_busy) begin
      n = 0;
      while (f_busy(s) && n < 200) begin
        n++;
        @(negedge clk);
      end
      check("busy_cycles", 64'(n), (s == 0) ? 64'(17) : 64'(25));
    end
    check("move_count", f_count(s), 64'(mc[s]));
    check("board", f_board(s), mb[s]);
  endtask

  task automatic add(input int s, input logic [1:0] p, input int position,
                     input logic acc, input logic [2:0] code);
    tbl.push_back('{s, p, position, acc, code});
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) drive(tbl[i].sel, tbl[i].pl, tbl[i].p, tbl[i].acc, tbl[i].code, 1'b1);
    tbl.delete();
  endtask

  task automatic clear_game(input int s);
    if (s == 0) ng3 = 1'b1; else ng5 = 1'b1;
    @(negedge clk);
    ng3 = 1'b0;
    ng5 = 1'b0;
    mb[s] = '0;
    mc[s] = 0;
  endtask

  task automatic chk_reset(input int s);
    check("rst_busy", 64'(f_busy(s)), 64'(0));
    check("rst_accept", 64'(f_acc(s)), 64'(0));
    check("rst_reject", 64'(f_rej(s)), 64'(0));
    check("rst_code", 64'(f_rc(s)), 64'(0));
    check("rst_turn", 64'(f_turn(s)), 64'(1));
    check("rst_winner", 64'(f_win(s)), 64'(0));
    check("rst_game_over", 64'(f_go(s)), 64'(0));
    check("rst_draw", 64'(f_draw(s)), 64'(0));
    check("rst_count", f_count(s), 64'(0));
    check("rst_board", f_board(s), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    mb[0] = '0; mb[1] = '0; mc[0] = 0; mc[1] = 0;
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    reset = 1'b0;
    @(negedge clk);

    // 3x3 game won by P1 on the main diagonal, with two occupied-cell rejects
    add(0, 2'b01, 1, 1, 0); add(0, 2'b10, 2, 1, 0); add(0, 2'b01, 4, 1, 0);
    add(0, 2'b10, 7, 1, 0); add(0, 2'b01, 4, 0, 3); add(0, 2'b01, 5, 1, 0);
    add(0, 2'b10, 1, 0, 3); add(0, 2'b10, 8, 1, 0); add(0, 2'b01, 9, 1, 0);
    run_tbl();
    check("win3_winner", 64'(win3), 64'(1));
    check("win3_game_over", 64'(go3), 64'(1));
    check("win3_count", 64'(cnt3), 64'(7));
    check("win3_board", 64'(board3), mk(9, 64'h119, 64'h0C2));
    check("win3_turn", 64'(turn3), 64'(1));

    // 3x3 draw, then a strobe into a finished game
    clear_game(0);
    add(0, 2'b01, 1, 1, 0); add(0, 2'b10, 2, 1, 0); add(0, 2'b01, 3, 1, 0);
    add(0, 2'b10, 5, 1, 0); add(0, 2'b01, 4, 1, 0); add(0, 2'b10, 6, 1, 0);
    add(0, 2'b01, 8, 1, 0); add(0, 2'b10, 7, 1, 0); add(0, 2'b01, 9, 1, 0);
    add(0, 2'b01, 1, 0, 4);
    run_tbl();
    check("draw3_draw", 64'(draw3), 64'(1));
    check("draw3_game_over", 64'(go3), 64'(1));
    check("draw3_winner", 64'(win3), 64'(0));
    check("draw3_count", 64'(cnt3), 64'(9));

    // reject reasons, including a strobe during a scan
    clear_game(0);
    add(0, 2'b10, 1, 0, 1); add(0, 2'b01, 0, 0, 2); add(0, 2'b01, 10, 0, 2);
    add(0, 2'b11, 1, 0, 1);
    run_tbl();
    drive(0, 2'b01, 5, 1, 0, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 2'b10, 1, 0, 4, 1'b1);
    n = 0;
    while (busy3 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_end", 64'(busy3), 64'(0));
    check("rej_turn", 64'(turn3), 64'(2));

    // new_game five cycles into a scan, coincident with a strobe
    drive(0, 2'b10, 1, 1, 0, 1'b0);
    repeat (4) @(negedge clk);
    ng3 = 1'b1;
    stb3 = 1'b1;
    pl = 2'b01;
    posv = 5'd2;
    @(negedge clk);
    ng3 = 1'b0;
    stb3 = 1'b0;
    mb[0] = '0;
    mc[0] = 0;
    #1;
    chk_reset(0);
    repeat (3) @(negedge clk);
    check("ng_busy_after", 64'(busy3), 64'(0));

    // 5x5, K=4: P2's three-in-a-row is not enough, P1's four is
    add(1, 2'b01, 1, 1, 0); add(1, 2'b10, 6, 1, 0); add(1, 2'b01, 2, 1, 0);
    add(1, 2'b10, 7, 1, 0); add(1, 2'b01, 3, 1, 0); add(1, 2'b10, 8, 1, 0);
    run_tbl();
    check("win5_early_winner", 64'(win5), 64'(0));
    check("win5_early_game_over", 64'(go5), 64'(0));
    add(1, 2'b01, 4, 1, 0);
    run_tbl();
    check("win5_winner", 64'(win5), 64'(1));
    check("win5_game_over", 64'(go5), 64'(1));
    check("win5_count", 64'(cnt5), 64'(7));

    // 5x5 cells 4..7 are consecutive indices but straddle a row edge
    clear_game(1);
    add(1, 2'b01, 4, 1, 0); add(1, 2'b10, 11, 1, 0); add(1, 2'b01, 5, 1, 0);
    add(1, 2'b10, 12, 1, 0); add(1, 2'b01, 6, 1, 0); add(1, 2'b10, 13, 1, 0);
    add(1, 2'b01, 7, 1, 0);
    run_tbl();
    check("wrap_winner", 64'(win5), 64'(0));
    check("wrap_turn", 64'(turn5), 64'(2));
    check("wrap_game_over", 64'(go5), 64'(0));

    // asynchronous reset in the middle of a scan
    drive(1, 2'b10, 0, 0, 2, 1'b1);
    drive(1, 2'b10, 20, 1, 0, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    mb[0] = '0; mb[1] = '0; mc[0] = 0; mc[1] = 0;
    chk_reset(1);
    chk_reset(0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("final_queue_empty", 64'(sbq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
